alu_exec_unit: RTL and testbench

- Execute-side consumer of the ALU operand/control decoder output.
- Takes the decoded operand pair and one-hot op type, and computes result, zero and less-than flags.
- Returns them through a valid/ready output register.
- Add/logic/compare ops complete in one cycle; shifts run on an iterative multi-bit shifter so no 32-bit barrel shifter is needed on the EXU critical path.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_iter_shifter.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 127 ++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encodings, EXU state and shifter direction types.
// Imported by alu_exec_unit and alu_iter_shifter.
package alu_pkg;

  localparam int ALU_TYPE = 8;

  localparam int ALU_ADD = 0;
  localparam int ALU_SLL = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_XOR = 3;
  localparam int ALU_SRL = 4;
  localparam int ALU_SRA = 5;
  localparam int ALU_OR  = 6;
  localparam int ALU_AND = 7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} exu_state_t;

  typedef enum logic [1:0] {SH_LEFT, SH_RIGHT, SH_RIGHT_ARITH} shift_kind_t;

  // Keeps only the lowest set bit so multi-hot selects resolve by index order.
  function automatic logic [ALU_TYPE-1:0] lowest_set(input logic [ALU_TYPE-1:0] v);
    return v & (~v + ALU_TYPE'(1));
  endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle, ceil(shamt/SHIFT_STEP) cycles.
// done_o flags the final step; result_o is the post-step value to capture that cycle.
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  shift_kind_t     kind_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [4:0]      shamt_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  logic [XLEN-1:0]   work_q, work_d;
  logic [5:0]        rem_q, rem_d, k;
  shift_kind_t       kind_q;
  logic              fill_q;
  logic [2*XLEN-1:0] right_ext;

  always_comb begin
    k         = (rem_q > STEP) ? STEP : rem_q;
    // fill_q carries the original sign bit for SRA and 0 for SRL
    right_ext = {{XLEN{fill_q}}, work_q} >> k;
    work_d    = (kind_q == SH_LEFT) ? (work_q << k) : right_ext[XLEN-1:0];
    rem_d     = rem_q - k;
  end

  assign busy_o   = (rem_q != 6'd0);
  assign done_o   = busy_o && (rem_q <= STEP);
  assign result_o = work_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      work_q <= '0;
      rem_q  <= '0;
      kind_q <= SH_LEFT;
      fill_q <= 1'b0;
    end else if (flush_i) begin
      rem_q <= '0;
    end else if (start_i) begin
      work_q <= a_i;
      rem_q  <= {1'b0, shamt_i};
      kind_q <= kind_i;
      fill_q <= (kind_i == SH_RIGHT_ARITH) & a_i[XLEN-1];
    end else if (busy_o) begin
      work_q <= work_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: add/logic/compare in 1 cycle, shifts in 1+ceil(shamt/SHIFT_STEP) cycles.
// Result held in a valid/ready register; o_ready = IDLE | (DONE & i_ready); flush beats accept.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 4,
  parameter int XLEN       = 32
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [XLEN-1:0]     i_alu_a,
  input  logic [XLEN-1:0]     i_alu_b,
  input  logic                i_alu_sub,
  input  logic                i_alu_sign,
  input  logic [ALU_TYPE-1:0] i_alu_t,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [XLEN-1:0]     o_result,
  output logic                o_zero,
  output logic                o_less
);

  exu_state_t          state_q;
  logic                valid_q, zero_q, less_q;
  logic [XLEN-1:0]     result_q;

  logic [ALU_TYPE-1:0] t_sel;
  logic [XLEN:0]       sum;
  logic                carry, ovf, less, zero;
  logic                is_shift, accept, sh_start, sh_busy, sh_done;
  logic [XLEN-1:0]     alu_res, sh_result;
  shift_kind_t         sh_kind;

  assign t_sel = lowest_set(i_alu_t);

  // b arrives pre-inverted for subtract, so the overflow test uses it as-is
  assign sum   = {1'b0, i_alu_a} + {1'b0, i_alu_b} + {{XLEN{1'b0}}, i_alu_sub};
  assign carry = sum[XLEN];
  assign ovf   = (i_alu_a[XLEN-1] == i_alu_b[XLEN-1]) & (sum[XLEN-1] != i_alu_a[XLEN-1]);
  assign less  = i_alu_sign ? (sum[XLEN-1] ^ ovf) : ~carry;
  assign zero  = (sum[XLEN-1:0] == '0);

  assign is_shift = t_sel[ALU_SLL] | t_sel[ALU_SRL] | t_sel[ALU_SRA];
  assign sh_kind  = t_sel[ALU_SLL] ? SH_LEFT : (t_sel[ALU_SRA] ? SH_RIGHT_ARITH : SH_RIGHT);

  always_comb begin
    alu_res = '0;
    if (t_sel[ALU_ADD])      alu_res = sum[XLEN-1:0];
    else if (t_sel[ALU_SLT]) alu_res = {{(XLEN-1){1'b0}}, less};
    else if (t_sel[ALU_XOR]) alu_res = i_alu_a ^ i_alu_b;
    else if (t_sel[ALU_OR])  alu_res = i_alu_a | i_alu_b;
    else if (t_sel[ALU_AND]) alu_res = i_alu_a & i_alu_b;
    else if (is_shift)       alu_res = i_alu_a;
  end

  assign o_ready  = (state_q == IDLE) | ((state_q == DONE) & i_ready);
  assign accept   = i_valid & o_ready & ~i_flush;
  assign sh_start = accept & is_shift & (i_alu_b[4:0] != 5'd0);

  alu_iter_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk_i    (i_clock),
    .rst_ni   (i_reset_n),
    .start_i  (sh_start),
    .flush_i  (i_flush),
    .kind_i   (sh_kind),
    .a_i      (i_alu_a),
    .shamt_i  (i_alu_b[4:0]),
    .busy_o   (sh_busy),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      zero_q <= zero;
      less_q <= less;
      if (sh_start) begin
        state_q <= SHIFT;
        valid_q <= 1'b0;
      end else begin
        result_q <= alu_res;
        state_q  <= DONE;
        valid_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          if (sh_done) begin
            result_q <= sh_result;
            state_q  <= DONE;
            valid_q  <= 1'b1;
          end else if (!sh_busy) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_zero   = zero_q;
  assign o_less   = less_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: stimulus pushes expected results, a monitor pops and checks them.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic                i_clock = 1'b0;
  logic                i_reset_n = 1'b0;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic [31:0]         i_alu_a = '0;
  logic [31:0]         i_alu_b = '0;
  logic                i_alu_sub = 1'b0;
  logic                i_alu_sign = 1'b0;
  logic [ALU_TYPE-1:0] i_alu_t = '0;
  logic                i_flush = 1'b0;
  logic                o_valid;
  logic                i_ready = 1'b1;
  logic [31:0]         o_result;
  logic                o_zero;
  logic                o_less;

  alu_exec_unit #(.SHIFT_STEP(4), .XLEN(32)) dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_alu_a    (i_alu_a),
    .i_alu_b    (i_alu_b),
    .i_alu_sub  (i_alu_sub),
    .i_alu_sign (i_alu_sign),
    .i_alu_t    (i_alu_t),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_less     (o_less)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        l;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   presented = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  // Monitor: checks each result the first cycle it is presented.
  always @(negedge i_clock) begin
    if (!i_reset_n || !o_valid) begin
      presented = 0;
    end else begin
      if (!presented) begin
        presented = 1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got result %h with no pending op", o_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_res"}, o_result, e.res);
          chk({e.name, "_zero"}, {31'b0, o_zero}, {31'b0, e.z});
          chk({e.name, "_less"}, {31'b0, o_less}, {31'b0, e.l});
          chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (i_ready) presented = 0;
    end
  end

  // Called at posedge+#1; returns at accept-edge+#2 with i_valid dropped.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic sign, input logic [7:0] t,
                       input logic [31:0] res, input logic z, input logic l, input int lat,
                       input bit push, output int waited);
    exp_t e;
    i_valid = 1'b1; i_alu_a = a; i_alu_b = b; i_alu_sub = sub; i_alu_sign = sign; i_alu_t = t;
    #1;
    waited = 0;
    while (!o_ready && waited < 40) begin
      @(posedge i_clock); #1; waited++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: o_ready stayed %b", name, o_ready);
      i_valid = 1'b0;
    end else begin
      @(posedge i_clock);
      #1;
      i_valid = 1'b0;
      if (push) begin
        e.name = name; e.res = res; e.z = z; e.l = l; e.lat = lat; e.acc = cyc - 1;
        sb.push_back(e);
      end
      #1;
    end
  endtask

  initial begin
    int w;
    #2;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_zero", {31'b0, o_zero}, 32'd0);
    chk("rst_less", {31'b0, o_less}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    @(posedge i_clock); #1;
    i_reset_n = 1'b1;
    @(posedge i_clock); #1;

    issue("add", 32'd5, 32'd7, 0, 0, oh(ALU_ADD), 32'd12, 0, 1, 1, 1, w);
    issue("sub_s", 32'd3, 32'hFFFF_FFFA, 1, 1, oh(ALU_ADD), 32'hFFFF_FFFE, 0, 1, 1, 1, w);
    issue("sub_u", 32'd3, 32'hFFFF_FFFA, 1, 0, oh(ALU_ADD), 32'hFFFF_FFFE, 0, 1, 1, 1, w);
    issue("sub_eq", 32'd5, 32'hFFFF_FFFA, 1, 1, oh(ALU_ADD), 32'd0, 1, 0, 1, 1, w);
    issue("sra31", 32'h8000_0000, 32'd31, 0, 0, oh(ALU_SRA), 32'hFFFF_FFFF, 0, 1, 9, 1, w);
    issue("sra0", 32'h8000_0000, 32'd0, 0, 0, oh(ALU_SRA), 32'h8000_0000, 0, 1, 1, 1, w);
    issue("sll5", 32'd3, 32'd5, 0, 0, oh(ALU_SLL), 32'h0000_0060, 0, 1, 3, 1, w);
    issue("srl8", 32'hF000_0000, 32'd8, 0, 0, oh(ALU_SRL), 32'h00F0_0000, 0, 1, 3, 1, w);
    issue("srl4", 32'h1234_5678, 32'd4, 0, 0, oh(ALU_SRL), 32'h0123_4567, 0, 1, 2, 1, w);
    issue("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, oh(ALU_XOR), 32'h0FF0_0FF0, 0, 0, 1, 1, w);
    issue("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, oh(ALU_OR), 32'hFFF0_FFF0, 0, 0, 1, 1, w);
    issue("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, oh(ALU_AND), 32'hF000_F000, 0, 0, 1, 1, w);
    issue("mh_xor_and", 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, oh(ALU_XOR) | oh(ALU_AND),
          32'h0FF0_0FF0, 0, 0, 1, 1, w);
    issue("mh_add_sll", 32'd3, 32'd5, 0, 0, oh(ALU_ADD) | oh(ALU_SLL), 32'd8, 0, 1, 1, 1, w);
    issue("t_zero", 32'd3, 32'd5, 0, 0, 8'h00, 32'd0, 0, 1, 1, 1, w);

    // Backpressure: result and flags hold while downstream stalls.
    @(posedge i_clock); #1;
    i_ready = 1'b0;
    issue("bp_add", 32'd10, 32'd20, 0, 0, oh(ALU_ADD), 32'd30, 0, 1, 1, 1, w);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clock); #1;
      chk("bp_hold_res", o_result, 32'd30);
      chk("bp_hold_zero", {31'b0, o_zero}, 32'd0);
      chk("bp_hold_less", {31'b0, o_less}, 32'd1);
      chk("bp_hold_ready", {31'b0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    issue("slt", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1, oh(ALU_SLT), 32'd1, 0, 1, 1, 1, w);
    chk("slt_same_cycle_accept", 32'(w), 32'd0);

    // Flush during the second shift cycle drops the op.
    @(posedge i_clock); #1;
    issue("flush_sll", 32'd1, 32'd20, 0, 0, oh(ALU_SLL), 32'd0, 0, 0, 0, 0, w);
    @(posedge i_clock); #1;
    i_flush = 1'b1;
    @(posedge i_clock); #1;
    i_flush = 1'b0;
    chk("flush_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_idle_ready", {31'b0, o_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clock); #1;
      chk("flush_no_valid", {31'b0, o_valid}, 32'd0);
    end
    issue("post_flush_add", 32'd1, 32'd1, 0, 0, oh(ALU_ADD), 32'd2, 0, 1, 1, 1, w);

    // Asynchronous reset during a shift clears outputs at once.
    @(posedge i_clock); #1;
    issue("rst_sll", 32'd1, 32'd20, 0, 0, oh(ALU_SLL), 32'd0, 0, 0, 0, 0, w);
    @(posedge i_clock); #1;
    i_reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst_result", o_result, 32'd0);
    chk("midrst_less", {31'b0, o_less}, 32'd0);
    @(posedge i_clock); #1;
    i_reset_n = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, o_ready}, 32'd1);
    @(posedge i_clock); #1;
    issue("post_rst_sub", 32'd7, 32'hFFFF_FFF8, 1, 1, oh(ALU_ADD), 32'd0, 1, 0, 1, 1, w);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge i_clock);
    @(posedge i_clock); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
